// File: rtl/collision_detector.sv
// Per-pixel ball collision detector: turns smiley/object draw overlaps into debounced
// per-object pulses, a per-frame collision mask and the first contact coordinate.
module collision_detector #(
  parameter int MIN_OVERLAP     = 4,
  parameter int COOLDOWN_FRAMES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        draw_smiley,
  input  logic        draw_flipper,
  input  logic        drawObstacle,
  input  logic        drawBorder,
  output logic [2:0]  collision_pulse,
  output logic [2:0]  collision_mask,
  output logic [10:0] contact_x,
  output logic [10:0] contact_y,
  output logic        contact_valid
);

  localparam logic [7:0] MIN_CNT = 8'(MIN_OVERLAP);
  // The firing frame itself consumes one decrement, so load one extra.
  localparam logic [4:0] CD_LOAD = 5'(COOLDOWN_FRAMES + 1);

  logic [2:0]  overlap;
  logic [7:0]  cnt_q [3];
  logic [7:0]  cnt_d [3];
  logic [4:0]  cd_q  [3];
  logic [4:0]  cd_d  [3];
  logic [2:0]  fired_q, fired_d, fire;
  logic        staged_v_q, staged_v_d;
  logic [10:0] staged_x_q, staged_x_d, staged_y_q, staged_y_d;

  assign overlap = {drawBorder, drawObstacle, draw_flipper} & {3{draw_smiley}};

  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
    fire       = '0;
    fired_d    = startOfFrame ? 3'b000 : fired_q;
    staged_v_d = startOfFrame ? 1'b0 : staged_v_q;
    staged_x_d = startOfFrame ? 11'd0 : staged_x_q;
    staged_y_d = startOfFrame ? 11'd0 : staged_y_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = startOfFrame ? 8'd0 : cnt_q[i];
      cd_d[i]  = (startOfFrame && cd_q[i] != 5'd0) ? cd_q[i] - 5'd1 : cd_q[i];
      // A startOfFrame pixel is judged against the already-restarted frame state.
      if (overlap[i] && !fired_d[i] && cd_d[i] == 5'd0) begin
        cnt_d[i] = cnt_d[i] + 8'd1;
        if (cnt_d[i] == MIN_CNT) begin
          fire[i]    = 1'b1;
          fired_d[i] = 1'b1;
          cd_d[i]    = CD_LOAD;
        end
      end
    end
    if (|overlap && !staged_v_d) begin
      staged_v_d = 1'b1;
      staged_x_d = pixelX;
      staged_y_d = pixelY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the per-object arrays are tiny registers, so they are reset like any other state.
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
        cd_q[i]  <= '0;
      end
      fired_q         <= '0;
      staged_v_q      <= 1'b0;
      staged_x_q      <= '0;
      staged_y_q      <= '0;
      collision_pulse <= '0;
      collision_mask  <= '0;
      contact_x       <= '0;
      contact_y       <= '0;
      contact_valid   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
        cd_q[i]  <= cd_d[i];
      end
      fired_q         <= fired_d;
      staged_v_q      <= staged_v_d;
      staged_x_q      <= staged_x_d;
      staged_y_q      <= staged_y_d;
      collision_pulse <= fire;
      if (startOfFrame) begin
        collision_mask <= fired_q;
        contact_x      <= staged_x_q;
        contact_y      <= staged_y_q;
        contact_valid  <= staged_v_q;
      end
    end
  end

endmodule

// File: tb/tb_collision_detector.sv
// Bench for collision_detector: directed vector table, hand-written corner sequences and
// random traffic, all checked against a frame-numbered reference model on two configurations.
module tb_collision_detector;

  localparam int MIN_A = 4;
  localparam int CD_A  = 3;
  localparam int MIN_B = 1;
  localparam int CD_B  = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        sof, sm;
  logic [2:0]  dr;
  logic [10:0] px, py;

  logic [2:0]  pulse_a, mask_a, pulse_b, mask_b;
  logic [10:0] cx_a, cy_a, cx_b, cy_b;
  logic        cv_a, cv_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  collision_detector #(.MIN_OVERLAP(MIN_A), .COOLDOWN_FRAMES(CD_A)) dut_a (
    .clk(clk), .reset(reset), .startOfFrame(sof), .pixelX(px), .pixelY(py),
    .draw_smiley(sm), .draw_flipper(dr[0]), .drawObstacle(dr[1]), .drawBorder(dr[2]),
    .collision_pulse(pulse_a), .collision_mask(mask_a),
    .contact_x(cx_a), .contact_y(cy_a), .contact_valid(cv_a)
  );

  collision_detector #(.MIN_OVERLAP(MIN_B), .COOLDOWN_FRAMES(CD_B)) dut_b (
    .clk(clk), .reset(reset), .startOfFrame(sof), .pixelX(px), .pixelY(py),
    .draw_smiley(sm), .draw_flipper(dr[0]), .drawObstacle(dr[1]), .drawBorder(dr[2]),
    .collision_pulse(pulse_b), .collision_mask(mask_b),
    .contact_x(cx_b), .contact_y(cy_b), .contact_valid(cv_b)
  );

  // Reference model: frames are numbered, and an object is eligible when the current frame
  // number exceeds its last firing frame by more than the cooldown.
  int          m_frame [2];
  int          m_cnt   [2][3];
  bit          m_fired [2][3];
  int          m_last  [2][3];
  bit          m_sv    [2];
  logic [10:0] m_sx    [2];
  logic [10:0] m_sy    [2];
  logic [2:0]  e_pulse [2];
  logic [2:0]  e_mask  [2];
  logic [10:0] e_cx    [2];
  logic [10:0] e_cy    [2];
  logic        e_cv    [2];

  function automatic int cfg_min(input int c);
    return (c == 0) ? MIN_A : MIN_B;
  endfunction

  function automatic int cfg_cd(input int c);
    return (c == 0) ? CD_A : CD_B;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_frame[c] = 0;
      m_sv[c] = 0; m_sx[c] = '0; m_sy[c] = '0;
      e_pulse[c] = '0; e_mask[c] = '0; e_cx[c] = '0; e_cy[c] = '0; e_cv[c] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_cnt[c][i] = 0; m_fired[c][i] = 0; m_last[c][i] = -100;
      end
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      logic [2:0] pb;
      pb = '0;
      if (sof) begin
        e_mask[c] = {m_fired[c][2], m_fired[c][1], m_fired[c][0]};
        e_cx[c] = m_sx[c]; e_cy[c] = m_sy[c]; e_cv[c] = m_sv[c];
        m_frame[c]++;
        m_sv[c] = 0; m_sx[c] = '0; m_sy[c] = '0;
        for (int i = 0; i < 3; i++) begin
          m_cnt[c][i] = 0; m_fired[c][i] = 0;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (sm && dr[i] && !m_fired[c][i] && (m_frame[c] - m_last[c][i] > cfg_cd(c))) begin
          m_cnt[c][i]++;
          if (m_cnt[c][i] == cfg_min(c)) begin
            m_fired[c][i] = 1; m_last[c][i] = m_frame[c]; pb[i] = 1'b1;
          end
        end
      end
      if (sm && (dr != 3'b000) && !m_sv[c]) begin
        m_sv[c] = 1; m_sx[c] = px; m_sy[c] = py;
      end
      e_pulse[c] = pb;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_models();
    check("a_pulse", pulse_a, e_pulse[0]); check("a_mask", mask_a, e_mask[0]);
    check("a_cx", cx_a, e_cx[0]); check("a_cy", cy_a, e_cy[0]); check("a_cv", cv_a, e_cv[0]);
    check("b_pulse", pulse_b, e_pulse[1]); check("b_mask", mask_b, e_mask[1]);
    check("b_cx", cx_b, e_cx[1]); check("b_cy", cy_b, e_cy[1]); check("b_cv", cv_b, e_cv[1]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pulse_a"}, pulse_a, 0); check({tag, "_mask_a"}, mask_a, 0);
    check({tag, "_cx_a"}, cx_a, 0); check({tag, "_cy_a"}, cy_a, 0); check({tag, "_cv_a"}, cv_a, 0);
    check({tag, "_pulse_b"}, pulse_b, 0); check({tag, "_mask_b"}, mask_b, 0);
    check({tag, "_cx_b"}, cx_b, 0); check({tag, "_cy_b"}, cy_b, 0); check({tag, "_cv_b"}, cv_b, 0);
  endtask

  // One pixel cycle: drive, clock, advance the model, then compare away from the edge.
  task automatic step(input logic s, input int x, input int y, input logic m, input logic [2:0] d);
    sof = s; px = 11'(x); py = 11'(y); sm = m; dr = d;
    @(posedge clk);
    model_step();
    #1;
    check_models();
  endtask

  task automatic do_reset(input bit check_now);
    sof = 0; sm = 0; dr = '0; px = '0; py = '0;
    reset = 1'b1;
    model_reset();
    if (check_now) begin
      #2;
      check_zero("async_rst");
    end
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    reset = 1'b0;
  endtask

  typedef struct {
    logic        sof;
    int          x, y;
    logic        sm;
    logic [2:0]  dr;
    logic [2:0]  e_pulse, e_mask;
    logic        e_cv;
    logic [10:0] e_cx, e_cy;
  } vec_t;

  function automatic vec_t mk(input logic s, input int x, input int y, input logic m,
                              input logic [2:0] d, input logic [2:0] ep, input logic [2:0] em,
                              input logic ev, input int ex, input int ey);
    vec_t v;
    v.sof = s; v.x = x; v.y = y; v.sm = m; v.dr = d;
    v.e_pulse = ep; v.e_mask = em; v.e_cv = ev; v.e_cx = 11'(ex); v.e_cy = 11'(ey);
    return v;
  endfunction

  vec_t vecs [14];

  initial begin
    // Basic firing then below-threshold frame, expectations for the MIN=4 instance.
    vecs[0]  = mk(1,   0,   0, 0, 3'b000, 3'b000, 3'b000, 0,   0,   0);
    vecs[1]  = mk(0, 100, 200, 1, 3'b001, 3'b000, 3'b000, 0,   0,   0);
    vecs[2]  = mk(0, 101, 200, 1, 3'b001, 3'b000, 3'b000, 0,   0,   0);
    vecs[3]  = mk(0, 102, 200, 1, 3'b001, 3'b000, 3'b000, 0,   0,   0);
    vecs[4]  = mk(0, 103, 200, 1, 3'b001, 3'b001, 3'b000, 0,   0,   0);
    vecs[5]  = mk(0, 104, 200, 1, 3'b001, 3'b000, 3'b000, 0,   0,   0);
    vecs[6]  = mk(0,   0,   0, 0, 3'b000, 3'b000, 3'b000, 0,   0,   0);
    vecs[7]  = mk(1,   0,   0, 0, 3'b000, 3'b000, 3'b001, 1, 100, 200);
    vecs[8]  = mk(0,  50,  60, 1, 3'b010, 3'b000, 3'b001, 1, 100, 200);
    vecs[9]  = mk(0,  51,  60, 1, 3'b010, 3'b000, 3'b001, 1, 100, 200);
    vecs[10] = mk(0,  52,  60, 1, 3'b010, 3'b000, 3'b001, 1, 100, 200);
    vecs[11] = mk(1,   0,   0, 0, 3'b000, 3'b000, 3'b000, 1,  50,  60);
    vecs[12] = mk(0,   0,   0, 0, 3'b000, 3'b000, 3'b000, 1,  50,  60);
    vecs[13] = mk(1,   0,   0, 0, 3'b000, 3'b000, 3'b000, 0,   0,   0);

    do_reset(0);

    for (int n = 0; n < 14; n++) begin
      step(vecs[n].sof, vecs[n].x, vecs[n].y, vecs[n].sm, vecs[n].dr);
      check($sformatf("vec%0d_pulse", n), pulse_a, vecs[n].e_pulse);
      check($sformatf("vec%0d_mask", n), mask_a, vecs[n].e_mask);
      check($sformatf("vec%0d_cv", n), cv_a, vecs[n].e_cv);
      check($sformatf("vec%0d_cx", n), cx_a, vecs[n].e_cx);
      check($sformatf("vec%0d_cy", n), cy_a, vecs[n].e_cy);
    end

    // Cooldown: border fires in frame 0, frames 1..3 are blocked, frame 4 fires again.
    do_reset(0);
    for (int f = 0; f < 5; f++) begin
      step(1, 0, 0, 0, 3'b000);
      for (int k = 1; k <= 8; k++) begin
        step(0, k, 5, 1, 3'b100);
        check($sformatf("cd_f%0d_k%0d", f, k), pulse_a,
              (k == 4 && (f == 0 || f == 4)) ? 3'b100 : 3'b000);
      end
    end

    // Overlap on the startOfFrame pixel belongs to the new frame (MIN=1 instance).
    step(1, 0, 0, 1, 3'b110);
    check("sim_pulse_b", pulse_b, 3'b110);
    check("sim_prev_mask_b", mask_b, 3'b100);
    step(0, 7, 7, 0, 3'b000);
    step(1, 0, 0, 0, 3'b000);
    check("sim_mask_b", mask_b, 3'b110);
    check("sim_cv_b", cv_b, 1);
    check("sim_cx_b", cx_b, 0);
    check("sim_cy_b", cy_b, 0);

    // No ball: every object drawn, smiley absent.
    do_reset(0);
    step(1, 0, 0, 0, 3'b000);
    for (int k = 0; k < 20; k++) begin
      step(0, k, k, 0, 3'b111);
      check("noball_pulse_a", pulse_a, 0);
      check("noball_pulse_b", pulse_b, 0);
    end
    step(1, 0, 0, 0, 3'b000);
    check("noball_mask_a", mask_a, 0);
    check("noball_cv_b", cv_b, 0);

    // Reset mid-frame clears outputs at once and discards counts and cooldown.
    do_reset(0);
    step(1, 0, 0, 0, 3'b000);
    for (int k = 0; k < 4; k++) step(0, 10 + k, 20, 1, 3'b001);
    step(1, 0, 0, 0, 3'b000);
    check("pre_rst_mask_a", mask_a, 3'b001);
    for (int k = 0; k < 3; k++) step(0, 30 + k, 20, 1, 3'b001);
    do_reset(1);
    for (int k = 0; k < 3; k++) begin
      step(0, 40 + k, 20, 1, 3'b001);
      check("post_rst_quiet_a", pulse_a, 0);
    end
    step(0, 43, 20, 1, 3'b001);
    check("post_rst_fire_a", pulse_a, 3'b001);

    // Random traffic against the model.
    do_reset(0);
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 32) == 0, int'($urandom % 2048), int'($urandom % 2048),
           logic'($urandom % 2), 3'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/collision_detector.md
# collision_detector

Per-pixel collision detector for the pinball video pipeline. It runs alongside the RGB priority mux on the same raster scan. Where the mux merges the per-object draw requests into one pixel colour, this block decodes the same draw requests back into per-object ball-collision events. It emits debounced one-cycle collision pulses, a per-frame collision summary and the first contact coordinate, all consumed by the ball-physics and score logic.

## Interface
Parameters:
- MIN_OVERLAP, 4, overlapping pixels needed within one frame to declare a collision (legal 1..255)
- COOLDOWN_FRAMES, 3, whole frames after a firing frame during which that object cannot fire again (legal 0..15)

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- startOfFrame  in  1  one-cycle pulse; this cycle is the first pixel of a new frame
- pixelX  in  11  current pixel column
- pixelY  in  11  current pixel row
- draw_smiley  in  1  ball covers the current pixel
- draw_flipper  in  1  flipper covers the current pixel
- drawObstacle  in  1  obstacle covers the current pixel
- drawBorder  in  1  border wall covers the current pixel
- collision_pulse  out  3  [0] flipper, [1] obstacle, [2] border; one-cycle pulses
- collision_mask  out  3  objects that fired during the previous frame, same bit order
- contact_x  out  11  pixelX of the first overlap pixel of the previous frame
- contact_y  out  11  pixelY of the same pixel
- contact_valid  out  1  previous frame had at least one overlap pixel

## Operation
- Overlap definition: overlap_i = draw_smiley & draw_i, evaluated every cycle for i in {flipper, obstacle, border}.
- Per-object state:
  - cnt_i: overlap counter, saturating at MIN_OVERLAP.
  - fired_i: this object fired in the current frame.
  - cd_i: cooldown frame counter.
- Counting: each cycle with overlap_i=1, fired_i=0 and cd_i=0 increments cnt_i.
- Firing: the increment that reaches MIN_OVERLAP sets fired_i, loads cooldown, and drives collision_pulse[i]=1 on the next cycle.
- One pulse per object per frame: once fired_i=1, further overlaps in that frame are ignored.
- Cooldown: after firing in frame F, frames F+1..F+COOLDOWN_FRAMES are blocked for that object and frame F+COOLDOWN_FRAMES+1 is eligible. COOLDOWN_FRAMES=0 allows a firing every frame.
- Independence: objects are counted independently; several bits may pulse in the same cycle.
- Contact capture:
  - The first cycle of a frame with any overlap_i=1 stages {pixelX, pixelY} and sets a staged-valid flag.
  - Cooldown and fired state do not affect capture.
  - Later overlaps in the same frame do not overwrite the staged value.
- Frame boundary, on a startOfFrame cycle:
  - collision_mask <= fired bits; contact_x/contact_y/contact_valid <= staged values, all as they stood before this cycle.
  - cnt, fired and staging are cleared.
  - cd_i decrements if non-zero.
- Simultaneous startOfFrame and overlap: the overlap pixel belongs to the new frame. Counters restart and this pixel counts as 1, so with MIN_OVERLAP=1 it fires in the new frame. Capture stages this pixel for the new frame.
- Pulse landing on startOfFrame: a pulse from the last pixel of frame F appears on frame F+1's startOfFrame cycle. fired_i was still set before that cycle, so the pixel is included in the mask for F.
- Inputs with draw_smiley=0 have no effect.

## Timing
- Reset values, forced immediately and asynchronously: collision_pulse=0, collision_mask=0, contact_x=0, contact_y=0, contact_valid=0. All counters, flags and staging are 0.
- Reset mid-frame discards partial counts and cooldowns. Counting resumes on the first clock after release, with no startOfFrame required.
- collision_pulse: exactly 1 cycle after the qualifying pixel cycle, high for exactly 1 cycle.
- collision_mask and contact_*: update on the clock edge of the startOfFrame cycle, visible the cycle after, stable for the whole frame.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- **Basic firing:** MIN_OVERLAP=4; 10 consecutive flipper overlaps starting at (100,200) -> collision_pulse=3'b001 only, one cycle after the 4th overlap pixel. At next startOfFrame: collision_mask=3'b001, contact=(100,200), contact_valid=1.
- **Below threshold:** 3 obstacle overlaps at (50,60) then frame end -> no pulse, collision_mask=0, contact=(50,60), contact_valid=1. Next frame has no overlaps -> contact_valid=0.
- **Cooldown:** COOLDOWN_FRAMES=3; border fires in frame 0; 8 overlaps in each of frames 1-3 -> no pulses. Frame 4 -> pulse after the 4th overlap.
- **Simultaneous events:**
  - MIN_OVERLAP=1; obstacle and border both overlap the pixel on the startOfFrame cycle at (0,0) -> collision_pulse=3'b110 next cycle.
  - The mask from the prior frame is unaffected; contact=(0,0) after the following frame boundary.
- **No ball:** draw_flipper=drawObstacle=drawBorder=1 for a whole frame with draw_smiley=0 -> all outputs remain 0.
- **Reset mid-operation:** after 3 flipper overlaps, pulse reset for 2 cycles -> outputs 0 immediately. Then 3 more overlaps -> no pulse; the 4th -> pulse.
